// File: rtl/period_sched_pkg.sv
// Shared types and constants for the period_sched pulse scheduler.
package period_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int TPERIOD_DEF = 6;
  localparam int PW_DEF      = 1;

  // Bits needed to hold values 0..v-1 (at least 1 bit).
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/period_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_gnt,
  output logic       o_ptr
);

  logic r_ptr;

  // On a tie the requester that did not win last time takes the grant.
  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) o_gnt = r_ptr ? 2'b01 : 2'b10;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= 1'b1;
    end else if (i_advance) begin
      r_ptr <= o_gnt[1];
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/period_sched.sv
// Shares one pulse line between two requesters, spacing rising edges >= TPERIOD cycles.
module period_sched
  import period_sched_pkg::*;
#(
  parameter int TPERIOD = TPERIOD_DEF,
  parameter int PW      = PW_DEF
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic req0_in,
  input  logic req1_in,
  output logic gnt0_out,
  output logic gnt1_out,
  output logic y_out,
  output logic busy_out
);

  localparam int CW = clog2(TPERIOD);
  localparam logic [CW-1:0] C_PW_LAST = CW'(PW - 1);
  localparam logic [CW-1:0] C_LAST    = CW'(TPERIOD - 1);
  localparam bit SHORT_LOW = (PW == TPERIOD - 1);

  if (TPERIOD < 2 || PW < 1 || PW >= TPERIOD) begin : g_bad_params
    $error("period_sched: need TPERIOD >= 2 and 1 <= PW < TPERIOD");
  end

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_y, r_busy, r_gnt_pulse;
  logic          w_take, w_any, w_ptr;
  logic [1:0]    w_gnt;

  rr_arb2 u_arb (
    .i_clk     (clk_in),
    .i_rst     (rst_in),
    .i_req     ({req1_in, req0_in}),
    .i_advance (w_take),
    .o_gnt     (w_gnt),
    .o_ptr     (w_ptr)
  );

  assign w_any = |w_gnt;

  // Requests are only looked at in IDLE or on the last cycle of a period.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_take      = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_any) begin
          w_take      = 1'b1;
          w_state_nxt = HIGH;
        end
      end
      HIGH: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == C_PW_LAST) begin
          if (SHORT_LOW && !w_any) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = LOW;
          end
        end
      end
      LOW: begin
        if (r_cnt == C_LAST) begin
          w_cnt_nxt = '0;
          if (w_any) begin
            w_take      = 1'b1;
            w_state_nxt = HIGH;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_y         <= 1'b0;
      r_busy      <= 1'b0;
      r_gnt_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_y         <= (w_state_nxt == HIGH);
      r_busy      <= (w_state_nxt != IDLE);
      r_gnt_pulse <= w_take;
    end
  end

  // The arbiter pointer already holds the winner on the grant cycle.
  assign gnt0_out = r_gnt_pulse & ~w_ptr;
  assign gnt1_out = r_gnt_pulse &  w_ptr;
  assign y_out    = r_y;
  assign busy_out = r_busy;

endmodule

// File: tb/tb_period_sched.sv
// Randomized bench for period_sched: two instances (PW=1 and PW=3) share the request inputs.
module tb_period_sched;

  localparam int TP  = 6;
  localparam int PWA = 1;
  localparam int PWB = 3;
  localparam int N_CYC = 900;

  logic clk = 1'b1;
  logic rst, req0, req1;
  logic a_gnt0, a_gnt1, a_y, a_busy;
  logic b_gnt0, b_gnt1, b_y, b_busy;

  always #5 clk = ~clk;

  period_sched #(.TPERIOD(TP), .PW(PWA)) dut_a (
    .clk_in(clk), .rst_in(rst), .req0_in(req0), .req1_in(req1),
    .gnt0_out(a_gnt0), .gnt1_out(a_gnt1), .y_out(a_y), .busy_out(a_busy)
  );

  period_sched #(.TPERIOD(TP), .PW(PWB)) dut_b (
    .clk_in(clk), .rst_in(rst), .req0_in(req0), .req1_in(req1),
    .gnt0_out(b_gnt0), .gnt1_out(b_gnt1), .y_out(b_y), .busy_out(b_busy)
  );

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int mon_cyc = 0;

  // Reference model in terms of rise times: a pulse window lasts TP cycles from its rise.
  int m_edge = 0;
  int m_last_rise = 0;
  bit m_active = 1'b0;
  bit m_ptr = 1'b1;

  function automatic logic [7:0] model_step(input bit r, input bit q0, input bit q1,
                                             output logic [1:0] g);
    int age, na;
    bit win;
    logic ya, yb;
    m_edge++;
    age = m_edge - 1 - m_last_rise;
    g = 2'b00;
    if (r) begin
      m_active = 1'b0;
      m_ptr    = 1'b1;
    end else if ((!m_active || age == TP - 1) && (q0 || q1)) begin
      win         = (q0 && q1) ? !m_ptr : !q0;
      m_ptr       = win;
      g[win]      = 1'b1;
      m_last_rise = m_edge;
      m_active    = 1'b1;
    end else if (m_active && age >= TP - 1) begin
      m_active = 1'b0;
    end
    na = m_edge - m_last_rise;
    ya = m_active && (na < PWA);
    yb = m_active && (na < PWB);
    return {g[1], g[0], ya, m_active, g[1], g[0], yb, m_active};
  endfunction

  // Driver: inputs change on the falling edge, expectations pushed for the next rising edge.
  initial begin
    bit p0, p1, rr, hold;
    int prob;
    logic [1:0] lg;
    p0 = 1'b1; p1 = 1'b1; lg = 2'b00;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    for (int n = 0; n < N_CYC; n++) begin
      @(negedge clk);
      hold = (n < 40);
      prob = (n < 400) ? 15 : 60;
      if (n < 3) rr = 1'b1;
      else if (n >= 40) rr = ($urandom_range(0, 79) == 0);
      else rr = 1'b0;
      if (!hold) begin
        if (lg[0]) p0 = 1'b0;
        if (lg[1]) p1 = 1'b0;
        if (!p0 && $urandom_range(0, 99) < prob) p0 = 1'b1;
        else if (p0 && $urandom_range(0, 99) < 4) p0 = 1'b0;
        if (!p1 && $urandom_range(0, 99) < prob) p1 = 1'b1;
        else if (p1 && $urandom_range(0, 99) < 4) p1 = 1'b0;
      end
      rst  = rr;
      req0 = p0;
      req1 = p1;
      exp_q.push_back(model_step(rr, p0, p1, lg));
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Monitor: every cycle the DUTs present outputs; compare against the oldest expectation.
  initial begin
    logic [7:0] exp_v, got_v;
    forever begin
      @(posedge clk);
      #1;
      mon_cyc++;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got_v = {a_gnt1, a_gnt0, a_y, a_busy, b_gnt1, b_gnt0, b_y, b_busy};
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL outputs cycle %0d {g1,g0,y,busy}x2: got %b required %b",
                   mon_cyc, got_v, exp_v);
        end
      end
    end
  end

endmodule
